sync_prefetch_fifo_param: RTL and testbench
===========================================

SYNC_PREFETCH_FIFO_PARAM -- requirements
Module: sync_prefetch_fifo_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width (legal 1..1152).
REQ-002 SHALL have parameter DEPTH_WIDTH, default 10, log2 of capacity (legal 2..20); DEPTH = 2**DEPTH_WIDTH words.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, almost-full threshold.
REQ-004 SHALL have parameter AE_LEVEL, default 4, almost-empty threshold.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous clear of all contents and flags.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_data  input  DATA_WIDTH  write word.
REQ-010 SHALL have port wr_vld  output  1  FIFO can accept a word (not full).
REQ-011 SHALL have port rd_en  input  1  consumer accepts rd_data.
REQ-012 SHALL have port rd_data  output  DATA_WIDTH  head word, registered (first-word-fall-through).
REQ-013 SHALL have port rd_vld  output  1  rd_data holds a valid word.
REQ-014 SHALL have port level  output  DEPTH_WIDTH+1  words held, including the output register.
REQ-015 SHALL have ports almost_full, almost_empty  output  1 each  level >= AF_LEVEL / level <= AE_LEVEL.
REQ-016 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Write transfer SHALL occur exactly when wr_en & wr_vld at a clock edge; read transfer exactly when rd_en & rd_vld.
REQ-018 wr_vld SHALL be registered and depend only on level (wr_vld = level < DEPTH), never combinationally on rd_en.
REQ-019 Capacity SHALL be exactly DEPTH words counted across RAM plus output register.
REQ-020 Write into an empty FIFO SHALL present the word on rd_data with rd_vld=1 in the cycle after the write edge (latency 1).
REQ-021 After a read transfer with further words stored, the next word SHALL appear on rd_data in the next cycle with rd_vld held high (no bubble at sustained 1 word/cycle).
REQ-022 Simultaneous write and read transfer SHALL leave level unchanged, including at level 1 (written word becomes head next cycle).
REQ-023 At full, wr_en SHALL be ignored even if a read transfer occurs the same cycle; wr_vld rises the cycle after level drops below DEPTH.
REQ-024 wr_en while wr_vld=0 SHALL drop the word and set overflow; rd_en while rd_vld=0 SHALL be ignored and set underflow; both sticky until flush or reset.
REQ-025 level, almost_full, almost_empty SHALL be registered and reflect all transfers of the previous edge.
REQ-026 Read/write pointers SHALL be DEPTH_WIDTH bits and wrap modulo DEPTH without gaps.
REQ-027 flush SHALL take priority over same-cycle wr_en/rd_en: next cycle level=0, rd_vld=0, wr_vld=1, almost_empty=1, almost_full=0, overflow=underflow=0; data is discarded.
REQ-028 rd_data SHALL hold its value while rd_vld=1 and rd_en=0.

Reset
REQ-029 rst_n low SHALL immediately force: pointers 0, level 0, rd_vld 0, wr_vld 1, almost_empty 1, almost_full 0, overflow 0, underflow 0, rd_data all zeros.
REQ-030 RAM contents SHALL NOT be reset; no output may expose them before a write.
REQ-031 Reset deassertion SHALL be tolerated asynchronously; first write accepted at first edge with rst_n high.

Structure
REQ-032 Shared package sync_prefetch_fifo_pkg SHALL hold default DATA_WIDTH/DEPTH_WIDTH, legal-range limits and a level-width function (DEPTH_WIDTH+1).
REQ-033 Storage SHALL be one sub-module sync_fifo_ram: simple dual-port, one clock, registered read, DEPTH x DATA_WIDTH, inferable to block RAM.
REQ-034 Top SHALL contain pointers, level counter, prefetch/output register control and flags.

Verification (DATA_WIDTH=32, DEPTH_WIDTH=4, AF_LEVEL=12, AE_LEVEL=4)
REQ-035 Reset then write 0xA5A5_0001 once -> next cycle rd_vld=1, rd_data=0xA5A5_0001, level=1.
REQ-036 Write 16 words 0..15 no reads -> wr_vld=0 after 16th, level=16, almost_full=1; 17th write -> dropped, overflow=1; reading 16 returns 0..15 in order.
REQ-037 Steady wr_en=rd_en=1 for 40 cycles, ascending data -> rd_vld never drops after first, level constant, no loss across pointer wrap.
REQ-038 rd_en with FIFO empty -> underflow=1, level stays 0; flush -> underflow=0 next cycle.
REQ-039 Level 8 with flush, wr_en, rd_en all high -> next cycle level=0, rd_vld=0, wr_vld=1.
REQ-040 rst_n low mid-burst at level 5 -> outputs at reset values immediately; after release, first write returns its own data, not stale words.

Source files
------------

// File: rtl/sync_prefetch_fifo_pkg.sv
// Shared definitions for the prefetching synchronous FIFO: default sizes,
// legal parameter ranges, level width helper and write routing codes.
package sync_prefetch_fifo_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH_WIDTH = 10;

  localparam int MIN_DATA_WIDTH  = 1;
  localparam int MAX_DATA_WIDTH  = 1152;
  localparam int MIN_DEPTH_WIDTH = 2;
  localparam int MAX_DEPTH_WIDTH = 20;

  // level must represent 0..DEPTH inclusive
  function automatic int level_width(input int depth_width);
    return depth_width + 1;
  endfunction

  // Where an accepted write word lands this cycle
  typedef enum logic [1:0] {
    DST_NONE,
    DST_OUT,   // straight into the output register (FIFO otherwise drained)
    DST_MID,   // into the prefetch bypass slot (RAM empty, slot free)
    DST_RAM    // into block RAM behind older words
  } wr_dst_e;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM, one clock, registered read. No reset on the array or
// the read register so it maps onto block RAM.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // write port and enabled registered read; rdata holds when re is low
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_prefetch_fifo_param.sv
// First-word-fall-through FIFO around a registered-read RAM. Words flow
// RAM -> prefetch slot -> output register. The prefetch slot is either the
// RAM read register or a bypass register, which hides the RAM latency so the
// head advances every cycle. level counts RAM + slot + output register.
module sync_prefetch_fifo_param
  import sync_prefetch_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH,
  parameter int AF_LEVEL    = (1 << DEPTH_WIDTH) - 4,
  parameter int AE_LEVEL    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_vld,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_vld,
  output logic [DEPTH_WIDTH:0]  level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int LW = level_width(DEPTH_WIDTH);

  localparam logic [LW-1:0]          DEPTH_L = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [LW-1:0]          AF_L    = AF_LEVEL[LW-1:0];
  localparam logic [LW-1:0]          AE_L    = AE_LEVEL[LW-1:0];
  localparam logic [LW-1:0]          CNT_Z   = '0;
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};

  logic [DEPTH_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0]          ram_cnt, ram_cnt_nxt, level_nxt;
  logic                   mid_vld, mid_from_ram;
  logic [DATA_WIDTH-1:0]  mid_byp, ram_q, mid_data;

  logic    wr_xfer, rd_xfer, out_load, mid_take, mid_free, ram_empty, ram_issue;
  wr_dst_e wr_dst;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_dst == DST_RAM && !flush),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (ram_issue && !flush),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // transfer qualification and movement between storage stages
  always_comb begin
    wr_xfer   = wr_en & wr_vld;
    rd_xfer   = rd_en & rd_vld;
    out_load  = ~rd_vld | rd_xfer;       // output register free after this edge
    mid_take  = out_load & mid_vld;      // slot moves into output register
    mid_free  = ~mid_vld | mid_take;
    ram_empty = (ram_cnt == CNT_Z);
    ram_issue = ~ram_empty & mid_free;   // refill slot from RAM
    mid_data  = mid_from_ram ? ram_q : mid_byp;
  end

  // route an accepted write to the youngest empty stage that keeps order
  always_comb begin
    wr_dst = DST_NONE;
    if (wr_xfer) begin
      if (out_load && !mid_vld && ram_empty) wr_dst = DST_OUT;
      else if (mid_free && ram_empty)        wr_dst = DST_MID;
      else                                   wr_dst = DST_RAM;
    end
  end

  // next values of the occupancy counters
  always_comb begin
    level_nxt   = level + {{DEPTH_WIDTH{1'b0}}, wr_xfer} - {{DEPTH_WIDTH{1'b0}}, rd_xfer};
    ram_cnt_nxt = ram_cnt + {{DEPTH_WIDTH{1'b0}}, (wr_dst == DST_RAM)}
                          - {{DEPTH_WIDTH{1'b0}}, ram_issue};
  end

  // level, status flags and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level        <= '0;
      wr_vld       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      level        <= '0;
      wr_vld       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      level        <= level_nxt;
      wr_vld       <= level_nxt < DEPTH_L;
      almost_full  <= level_nxt >= AF_L;
      almost_empty <= level_nxt <= AE_L;
      if (wr_en && !wr_vld) overflow  <= 1'b1;
      if (rd_en && !rd_vld) underflow <= 1'b1;
    end
  end

  // RAM pointers and count of words still inside the RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
    end else begin
      ram_cnt <= ram_cnt_nxt;
      if (wr_dst == DST_RAM) wr_ptr <= wr_ptr + PTR_ONE;
      if (ram_issue)         rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // prefetch slot and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld       <= 1'b0;
      rd_data      <= '0;
      mid_vld      <= 1'b0;
      mid_from_ram <= 1'b0;
      mid_byp      <= '0;
    end else if (flush) begin
      rd_vld       <= 1'b0;
      rd_data      <= '0;
      mid_vld      <= 1'b0;
      mid_from_ram <= 1'b0;
    end else begin
      if (out_load) begin
        rd_vld <= mid_vld | (wr_dst == DST_OUT);
        if (mid_vld)                rd_data <= mid_data;
        else if (wr_dst == DST_OUT) rd_data <= wr_data;
      end
      mid_vld <= (mid_vld & ~mid_take) | ram_issue | (wr_dst == DST_MID);
      if (ram_issue) begin
        mid_from_ram <= 1'b1;
      end else if (wr_dst == DST_MID) begin
        mid_from_ram <= 1'b0;
        mid_byp      <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_sync_prefetch_fifo_param.sv
// Scoreboard bench for sync_prefetch_fifo_param (32-bit, 16 deep).
module tb_sync_prefetch_fifo_param;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_vld, rd_vld, almost_full, almost_empty, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [AW:0]   level;

  sync_prefetch_fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH_WIDTH(AW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_vld      (wr_vld),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_vld      (rd_vld),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb[$];
  int            mdl_lvl = 0;
  logic          exp_of = 1'b0;
  logic          exp_uf = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ":level"},  DW'(level),        DW'(mdl_lvl));
    chk({tag, ":rd_vld"}, DW'(rd_vld),       DW'(mdl_lvl > 0));
    chk({tag, ":wr_vld"}, DW'(wr_vld),       DW'(mdl_lvl < DEPTH));
    chk({tag, ":af"},     DW'(almost_full),  DW'(mdl_lvl >= AF));
    chk({tag, ":ae"},     DW'(almost_empty), DW'(mdl_lvl <= AE));
    chk({tag, ":ovf"},    DW'(overflow),     DW'(exp_of));
    chk({tag, ":udf"},    DW'(underflow),    DW'(exp_uf));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ":level"},   DW'(level),        0);
    chk({tag, ":rd_vld"},  DW'(rd_vld),       0);
    chk({tag, ":wr_vld"},  DW'(wr_vld),       1);
    chk({tag, ":af"},      DW'(almost_full),  0);
    chk({tag, ":ae"},      DW'(almost_empty), 1);
    chk({tag, ":ovf"},     DW'(overflow),     0);
    chk({tag, ":udf"},     DW'(underflow),    0);
    chk({tag, ":rd_data"}, rd_data,           0);
  endtask

  // One clock: drive, resolve transfers against the model, check after edge.
  task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic re, input logic fl);
    int pre;
    pre     = mdl_lvl;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    flush   = fl;
    if (fl) begin
      sb.delete();
      mdl_lvl = 0;
      exp_of  = 1'b0;
      exp_uf  = 1'b0;
    end else begin
      if (re) begin
        if (pre > 0) begin
          if (sb.size() == 0) chk("sb_underrun", 1, 0);
          else chk("rd_data", rd_data, sb.pop_front());
          mdl_lvl--;
        end else exp_uf = 1'b1;
      end
      if (we) begin
        if (pre < DEPTH) begin
          sb.push_back(wd);
          mdl_lvl++;
        end else exp_of = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    chk_state("cyc");
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && mdl_lvl > 0; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drained", DW'(sb.size()), 0);
  endtask

  initial begin
    int pre_lv[5] = '{1, 2, 3, 8, 16};

    // reset state
    #12;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single write, latency 1
    cyc(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    chk("single:rd_data", rd_data, 32'hA5A5_0001);
    chk("single:level", DW'(level), 1);
    cyc(1'b0, '0, 1'b1, 1'b0);

    // fill to capacity, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
    chk("full:wr_vld", DW'(wr_vld), 0);
    chk("full:af", DW'(almost_full), 1);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("full:overflow", DW'(overflow), 1);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("full:drained", DW'(sb.size()), 0);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // sustained write+read at several levels, across pointer wrap; full case
    // also shows a write ignored at full even with a same-cycle read
    foreach (pre_lv[k]) begin
      for (int i = 0; i < pre_lv[k]; i++) cyc(1'b1, 32'h1000_0000 + DW'(i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) cyc(1'b1, 32'h2000_0000 + DW'(k * 100 + i), 1'b1, 1'b0);
      drain();
      cyc(1'b0, '0, 1'b0, 1'b1);
    end

    // underflow and flush clearing it
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("uf:underflow", DW'(underflow), 1);
    chk("uf:level", DW'(level), 0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("uf:cleared", DW'(underflow), 0);

    // flush beats same-cycle write and read at level 8
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h3000_0000 + DW'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h3333_3333, 1'b1, 1'b1);
    chk("flush:level", DW'(level), 0);
    chk("flush:rd_vld", DW'(rd_vld), 0);
    chk("flush:wr_vld", DW'(wr_vld), 1);

    // random traffic: fill-biased then drain-biased
    for (int i = 0; i < 300; i++) begin
      logic we, re;
      we = (i < 150) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      re = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc(we, $urandom, re, 1'b0);
    end
    drain();
    cyc(1'b0, '0, 1'b0, 1'b1);

    // asynchronous reset mid-burst at level 5
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h5000_0000 + DW'(i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    sb.delete();
    mdl_lvl = 0;
    exp_of  = 1'b0;
    exp_uf  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 32'hC0DE_0040, 1'b0, 1'b0);
    chk("midrst:rd_data", rd_data, 32'hC0DE_0040);
    cyc(1'b1, 32'hC0DE_0041, 1'b1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
